i2c_rr_arbiter: RTL

- Shares one I2C_MASTER write engine between NUM_REQ requesters with a round-robin grant.
- Latches the winner's 7-bit address and 8-bit data, then launches the master with a one-cycle start pulse.
- Tracks the master's READY to detect transaction end, then returns a per-requester done pulse.
- Sits between sensor/display client blocks and the single I2C_MASTER instance on the bus.

---
 rtl/i2c_pkg.sv | 16 +
 rtl/i2c_rr_arbiter_rr_pick.sv | 35 +++
 rtl/i2c_rr_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C widths and round-robin arbiter state encoding.
// Ports: none (package).
// Imported by the arbiter top and its winner-select helper.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_LAUNCH    = 2'd1,
    ARB_WAIT_BUSY = 2'd2,
    ARB_WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/i2c_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner select, reusable by any bus arbiter.
// Ports: req (request vector), ptr (index of last winner) -> gnt (one-hot winner), idx (binary winner).
// Search starts at ptr+1 and wraps modulo NUM_REQ; gnt is all-zero when req is all-zero.
module rr_pick
  import i2c_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // Offsets 1..NUM_REQ visit every requester once, the last winner last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/i2c_rr_arbiter.sv
// i2c_rr_arbiter: shares one I2C master write engine between NUM_REQ requesters, round-robin.
// Ports: CLK_IW/RST_N_IW (async active-low); REQ/ADDR/DATA_IW from clients, GNT/DONE/ERR/BUSY_OW back;
//        M_START/M_ADDR/M_DATA_OW to the master, M_READY_IW from it. Optional watchdog: I2C_ARB_TIMEOUT_EN.
module i2c_rr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                 CLK_IW,
  input  logic                 RST_N_IW,
  input  logic [NUM_REQ-1:0]   REQ_IW,
  input  logic [NUM_REQ*7-1:0] ADDR_IW,
  input  logic [NUM_REQ*8-1:0] DATA_IW,
  output logic [NUM_REQ-1:0]   GNT_OW,
  output logic [NUM_REQ-1:0]   DONE_OW,
  output logic                 ERR_OW,
  output logic                 BUSY_OW,
  output logic                 M_START_OW,
  output logic [6:0]           M_ADDR_OW,
  output logic [7:0]           M_DATA_OW,
  input  logic                 M_READY_IW
);

  import i2c_pkg::*;

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t              state_q, state_d;
  logic                    grant, finish, timeout;
  logic [NUM_REQ-1:0]      pick_gnt;
  logic [IW-1:0]           pick_idx;
  logic [IW-1:0]           ptr_q, win_q;
  logic [NUM_REQ-1:0]      gnt_q, done_q;
  logic                    busy_q, start_q;
  logic [I2C_ADDR_W-1:0]   addr_q;
  logic [I2C_DATA_W-1:0]   data_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IW)
  ) u_pick (
    .req (REQ_IW),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_ff @(posedge CLK_IW or negedge RST_N_IW) begin
    if (!RST_N_IW) state_q <= ARB_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        // A master held in reset shows READY low, so nothing is granted.
        if ((|REQ_IW) && M_READY_IW) begin
          grant   = 1'b1;
          state_d = ARB_LAUNCH;
        end
      end
      ARB_LAUNCH: state_d = ARB_WAIT_BUSY;
      ARB_WAIT_BUSY: begin
        if (timeout) begin
          finish  = 1'b1;
          state_d = ARB_IDLE;
        end else if (!M_READY_IW) begin
          state_d = ARB_WAIT_DONE;
        end
      end
      ARB_WAIT_DONE: begin
        if (M_READY_IW || timeout) begin
          finish  = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK_IW or negedge RST_N_IW) begin
    if (!RST_N_IW) begin
      ptr_q   <= IW'(NUM_REQ - 1);
      win_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      // Start is registered off LAUNCH, so it rises the cycle after GNT.
      start_q <= (state_q == ARB_LAUNCH);
      busy_q  <= (state_d != ARB_IDLE);
      done_q  <= finish ? gnt_q : '0;
      if (grant) begin
        gnt_q  <= pick_gnt;
        win_q  <= pick_idx;
        addr_q <= ADDR_IW[pick_idx*I2C_ADDR_W +: I2C_ADDR_W];
        data_q <= DATA_IW[pick_idx*I2C_DATA_W +: I2C_DATA_W];
      end else if (finish) begin
        gnt_q <= '0;
      end
      if (finish) ptr_q <= win_q;
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             in_wait, err_q;

  assign in_wait = (state_q == ARB_WAIT_BUSY) || (state_q == ARB_WAIT_DONE);
  // Fires on the edge where the count would reach TIMEOUT_CYC.
  assign timeout = in_wait && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK_IW or negedge RST_N_IW) begin
    if (!RST_N_IW) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == ARB_LAUNCH) cnt_q <= '0;
      else if (in_wait)          cnt_q <= cnt_q + 1'b1;
      // A normal completion on the same edge wins over the watchdog.
      err_q <= timeout && !((state_q == ARB_WAIT_DONE) && M_READY_IW);
    end
  end

  assign ERR_OW = err_q;
`else
  assign timeout = 1'b0;
  assign ERR_OW  = 1'b0;
`endif

  assign GNT_OW     = gnt_q;
  assign DONE_OW    = done_q;
  assign BUSY_OW    = busy_q;
  assign M_START_OW = start_q;
  assign M_ADDR_OW  = addr_q;
  assign M_DATA_OW  = data_q;

endmodule
